spectrum_bar_scheduler: RTL and testbench
=========================================

SPECTRUM_BAR_SCHEDULER -- requirements
Module: spectrum_bar_scheduler

Interface
REQ-001 Parameter NBARS, default 16, meaning bars per channel per frame; power of two, 2..64.
REQ-002 Parameter BW_BAR, default 7, meaning bar-height width.
REQ-003 Parameter BW_IDX, default 4, meaning log2(NBARS).
REQ-004 Clock  input  1  single clock; all logic rising-edge.
REQ-005 Reset  input  1  synchronous, active-high.
REQ-006 ReqL  input  1  left-channel frame ready; level, held until AckL.
REQ-007 ReqR  input  1  right-channel frame ready; level, held until AckR.
REQ-008 AckL  output  1  one-cycle pulse, left frame fully issued.
REQ-009 AckR  output  1  one-cycle pulse, right frame fully issued.
REQ-010 Abort  input  1  synchronous frame cancel.
REQ-011 Gap  input  3  interpolation height forwarded to complementer; sampled at grant.
REQ-012 RdAddr  output  1+BW_IDX  bar memory address {ch, idx}; ch 0 = L, 1 = R.
REQ-013 RdData  input  BW_BAR  bar memory data, valid one cycle after RdAddr.
REQ-014 CStart  output  1  complementer start; level trigger, rising edge is the command.
REQ-015 CBar  output  BW_BAR  bar value to complementer.
REQ-016 CH  output  3  gap height to complementer.
REQ-017 CBusy  input  1  complementer busy.
REQ-018 Busy  output  1  high while a frame is being scheduled (state not IDLE).
REQ-019 Ch  output  1  channel currently granted.

Function
REQ-020 FSM states: IDLE, RD, LOAD, PULSE, GAP, WAIT, FIN; one-hot or binary is an implementation choice.
REQ-021 IDLE: if only one Req is high, grant that channel. If both are high, grant the channel not equal to LastCh (round-robin). On grant: latch ch into Ch, set idx=0, latch Gap into CH, go to RD.
REQ-022 RD: drive RdAddr={Ch,idx} (registered), go to LOAD.
REQ-023 LOAD: capture RdData into CBar, go to PULSE.
REQ-024 PULSE: CStart=1 for exactly one cycle, go to GAP.
REQ-025 GAP: CStart=0 and CBusy ignored for one cycle (complementer busy-set latency), go to WAIT.
REQ-026 WAIT: remain while CBusy=1. When CBusy=0: if idx==NBARS-1, go to FIN; otherwise idx+1 and go to RD.
REQ-027 FIN: pulse AckL or AckR per Ch for one cycle, set LastCh=Ch, go to IDLE. The next grant is evaluated in IDLE, never in FIN.
REQ-028 Minimum per-bar period is 5 cycles (RD..WAIT with CBusy already low). A frame of NBARS bars with CBusy never high takes 5*NBARS+1 cycles from grant to Ack.
REQ-029 CStart is low in every state except PULSE, so consecutive bars always produce a clean 0->1 edge.
REQ-030 CBar and CH hold their value from LOAD until the next LOAD or the next grant.
REQ-031 A Req deasserted mid-frame is ignored: the frame completes and Ack is still pulsed.
REQ-032 Abort=1 in any non-IDLE state: next state is IDLE, CStart=0, no Ack, LastCh unchanged. Abort has priority over every transition, including FIN. Abort in IDLE blocks grant that cycle.
REQ-033 idx is BW_IDX bits and never wraps within a frame; the FIN check in REQ-026 is the only terminal condition.
REQ-034 AckL and AckR are never high in the same cycle; Ack only for the granted channel.

Reset
REQ-035 Reset=1 at any edge, including mid-frame, forces IDLE on the next cycle, with: idx=0, LastCh=1 (so L wins the first tie), Ch=0, RdAddr=0, CBar=0, CH=0, CStart=0, AckL=AckR=0, Busy=0.
REQ-036 Reset has priority over Abort and all FSM transitions. The complementer is not reset by this block.

Verification
REQ-037 Single-channel frame: ReqL=1, Gap=3, CBusy model busy 4 cycles after each CStart edge -> RdAddr 0..15 in order, 16 CStart pulses, CH=3, one AckL, AckR=0.
REQ-038 Round-robin: ReqL=ReqR=1 from reset -> L frame then R frame (RdAddr 0x10..0x1F), then L again. Grants alternate with no back-to-back same-channel grant while both requests are held.
REQ-039 Zero-busy throughput: CBusy tied 0, NBARS=16 -> AckL exactly 81 cycles after the grant cycle; CStart high in 16 non-adjacent cycles.
REQ-040 Abort mid-frame: Abort pulse in WAIT at idx=7 -> IDLE next cycle, no Ack, CStart=0. Re-grant with ReqL still high restarts at idx=0.
REQ-041 Reset mid-frame: Reset during PULSE at idx=5 -> all outputs at the REQ-035 values next cycle. With ReqL=ReqR=1 after release, L is granted first.
REQ-042 Data path: memory model returns bar=addr*3 mod 128 -> CBar on each PULSE equals 3*RdAddr mod 128 for that bar; a stuck CBusy=1 holds WAIT indefinitely with no further RdAddr change.

Source files
------------

// File: rtl/spectrum_bar_scheduler.sv
// Spectrum bar scheduler: walks every bar of a granted channel frame, fetches it
// from bar memory and hands it to the gap complementer one bar at a time.
module spectrum_bar_scheduler #(
  parameter int NBARS  = 16,
  parameter int BW_BAR = 7,
  parameter int BW_IDX = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqL,
  input  logic              ReqR,
  output logic              AckL,
  output logic              AckR,
  input  logic              Abort,
  input  logic [2:0]        Gap,
  output logic [BW_IDX:0]   RdAddr,
  input  logic [BW_BAR-1:0] RdData,
  output logic              CStart,
  output logic [BW_BAR-1:0] CBar,
  output logic [2:0]        CH,
  input  logic              CBusy,
  output logic              Busy,
  output logic              Ch
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] PULSE = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam logic [2:0] WAIT  = 3'd5;
  localparam logic [2:0] FIN   = 3'd6;

  localparam logic [BW_IDX-1:0] LAST_IDX = BW_IDX'(NBARS - 1);

  logic [2:0]        state;
  logic [2:0]        nextState;
  logic [BW_IDX-1:0] idx;
  logic [BW_IDX-1:0] idxNext;
  logic              lastCh;
  logic              grant;
  logic              grantCh;
  logic              advance;

  // Round-robin only matters on a tie; a lone request always wins.
  always_comb begin
    grant   = (state == IDLE) && !Abort && (ReqL || ReqR);
    grantCh = (ReqL && ReqR) ? ~lastCh : ReqR;
    idxNext = idx + 1'b1;
    advance = (state == WAIT) && !Abort && !CBusy && (idx != LAST_IDX);
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (grant) nextState = RD;
      RD:      nextState = LOAD;
      LOAD:    nextState = PULSE;
      PULSE:   nextState = GAP;
      GAP:     nextState = WAIT;
      WAIT:    if (!CBusy) nextState = (idx == LAST_IDX) ? FIN : RD;
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (Abort) nextState = IDLE;
  end

  // RdAddr is loaded on entry to RD so the synchronous memory answers during LOAD.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      idx    <= '0;
      lastCh <= 1'b1;
      Ch     <= 1'b0;
      RdAddr <= '0;
      CBar   <= '0;
      CH     <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (grant) begin
            Ch     <= grantCh;
            idx    <= '0;
            CH     <= Gap;
            RdAddr <= {grantCh, {BW_IDX{1'b0}}};
          end
        end
        LOAD: begin
          if (!Abort) CBar <= RdData;
        end
        WAIT: begin
          if (advance) begin
            idx    <= idxNext;
            RdAddr <= {Ch, idxNext};
          end
        end
        FIN: begin
          if (!Abort) lastCh <= Ch;
        end
        default: ;
      endcase
    end
  end

  // An abort landing on FIN suppresses the acknowledge of that frame.
  always_comb begin
    CStart = (state == PULSE);
    Busy   = (state != IDLE);
    AckL   = (state == FIN) && !Abort && !Ch;
    AckR   = (state == FIN) && !Abort && Ch;
  end

endmodule

// File: tb/tb_spectrum_bar_scheduler.sv
// Self-checking bench for spectrum_bar_scheduler: random gap heights, busy lengths
// and request patterns compared against a frame-level model of the scheduler.
module tb_spectrum_bar_scheduler;
  localparam int NB = 16;

  logic       Clock = 1'b0;
  logic       Reset, ReqL, ReqR, Abort, CBusy;
  logic [2:0] Gap, CH;
  logic [4:0] RdAddr;
  logic [6:0] RdData, CBar;
  logic       CStart, AckL, AckR, Busy, Ch;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busyLen = 0;
  int busyCnt = 0;
  bit stuck = 1'b0;
  int expGap = 0;
  int modelLast = 1;
  int pulseAddr[$];
  int grantCyc[$];
  int grantChQ[$];
  int ackCyc[$];
  int ackChQ[$];
  int adjCnt = 0;
  int bothAck = 0;
  int monIdx = 0;
  bit prevCS = 1'b0;
  bit prevBusy = 1'b0;

  spectrum_bar_scheduler dut (
    .Clock(Clock), .Reset(Reset), .ReqL(ReqL), .ReqR(ReqR), .AckL(AckL), .AckR(AckR),
    .Abort(Abort), .Gap(Gap), .RdAddr(RdAddr), .RdData(RdData), .CStart(CStart),
    .CBar(CBar), .CH(CH), .CBusy(CBusy), .Busy(Busy), .Ch(Ch)
  );

  always #5 Clock = ~Clock;

  // Bar memory (one-cycle read latency) and complementer busy model.
  always @(posedge Clock) begin
    RdData <= 7'((int'(RdAddr) * 3) % 128);
    if (CStart) busyCnt <= busyLen;
    else if (busyCnt > 0) busyCnt <= busyCnt - 1;
  end
  assign CBusy = stuck || (busyCnt > 0);

  // Event log plus per-bar checks of address order, bar data and gap height.
  always @(negedge Clock) begin
    cyc++;
    if (Busy && !prevBusy) begin
      grantCyc.push_back(cyc);
      grantChQ.push_back(int'(Ch));
      monIdx = 0;
    end
    if (CStart) begin
      if (prevCS) adjCnt++;
      else begin
        pulseAddr.push_back(int'(RdAddr));
        checks++;
        if (RdAddr !== {Ch, 4'(monIdx)}) begin
          errors++; $display("FAIL bar_addr: got %h required %h", RdAddr, {Ch, 4'(monIdx)});
        end
        checks++;
        if (CBar !== 7'((int'(RdAddr) * 3) % 128)) begin
          errors++; $display("FAIL bar_data: addr %h got %0d required %0d", RdAddr, CBar, (int'(RdAddr) * 3) % 128);
        end
        checks++;
        if (CH !== 3'(expGap)) begin
          errors++; $display("FAIL gap_height: got %0d required %0d", CH, expGap);
        end
        monIdx++;
      end
    end
    if (AckL && AckR) bothAck++;
    if (AckL || AckR) begin
      ackCyc.push_back(cyc);
      ackChQ.push_back(int'(AckR));
    end
    prevCS = CStart;
    prevBusy = Busy;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    pulseAddr.delete(); grantCyc.delete(); grantChQ.delete();
    ackCyc.delete(); ackChQ.delete();
    adjCnt = 0; bothAck = 0;
  endtask

  // sel: 0 = acks, 1 = pulses, 2 = grants
  task automatic wait_q(input int sel, input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge Clock);
      if ((sel == 0 && ackCyc.size() >= n) || (sel == 1 && pulseAddr.size() >= n) ||
          (sel == 2 && grantCyc.size() >= n)) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; ReqL = 1'b1; ReqR = 1'($urandom); Abort = 1'b0; Gap = 3'($urandom);
    repeat (3) @(posedge Clock);
    @(negedge Clock); #1;
    checks += 8;
    if (Busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b required 0", Busy); end
    if (CStart !== 1'b0) begin errors++; $display("FAIL reset_cstart: got %b required 0", CStart); end
    if (AckL !== 1'b0)   begin errors++; $display("FAIL reset_ackl: got %b required 0", AckL); end
    if (AckR !== 1'b0)   begin errors++; $display("FAIL reset_ackr: got %b required 0", AckR); end
    if (RdAddr !== 5'd0) begin errors++; $display("FAIL reset_rdaddr: got %h required 0", RdAddr); end
    if (CBar !== 7'd0)   begin errors++; $display("FAIL reset_cbar: got %h required 0", CBar); end
    if (CH !== 3'd0)     begin errors++; $display("FAIL reset_ch_height: got %h required 0", CH); end
    if (Ch !== 1'b0)     begin errors++; $display("FAIL reset_ch: got %b required 0", Ch); end
    @(posedge Clock); #1;
    Reset = 1'b0; ReqL = 1'b0; ReqR = 1'b0;
    modelLast = 1;
    clear_log();
  endtask

  task automatic test_single_frame();
    bit ok;
    int ch, g, b, lat;
    for (int it = 0; it < 3; it++) begin
      ch = (it == 0) ? 0 : int'($urandom_range(0, 1));
      g  = (it == 0) ? 3 : int'($urandom_range(0, 7));
      b  = (it == 0) ? 4 : int'($urandom_range(0, 6));
      busyLen = b; Gap = 3'(g); expGap = g;
      clear_log();
      if (ch == 1) ReqR = 1'b1; else ReqL = 1'b1;
      wait_q(0, 1, 400, ok);
      ReqL = 1'b0; ReqR = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL single_timeout: got no ack required one"); end
      else begin
        lat = NB * (4 + ((b > 1) ? b : 1)) + 1;
        checks += 6;
        if (grantChQ[0] !== ch) begin errors++; $display("FAIL single_grant: got %0d required %0d", grantChQ[0], ch); end
        if (ackChQ[0] !== ch) begin errors++; $display("FAIL single_ackch: got %0d required %0d", ackChQ[0], ch); end
        if (pulseAddr.size() !== NB) begin errors++; $display("FAIL single_pulses: got %0d required %0d", pulseAddr.size(), NB); end
        if (ackCyc[0] - (grantCyc[0] - 1) !== lat) begin
          errors++; $display("FAIL single_latency: got %0d required %0d", ackCyc[0] - (grantCyc[0] - 1), lat);
        end
        if (bothAck !== 0) begin errors++; $display("FAIL single_bothack: got %0d required 0", bothAck); end
        if (adjCnt !== 0) begin errors++; $display("FAIL single_adjacent: got %0d required 0", adjCnt); end
        modelLast = ch;
      end
      repeat (2) @(posedge Clock); #1;
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp;
    @(posedge Clock); #1 Reset = 1'b1;
    @(posedge Clock); #1 Reset = 1'b0;
    modelLast = 1;
    busyLen = int'($urandom_range(0, 2)); expGap = int'($urandom_range(0, 7)); Gap = 3'(expGap);
    clear_log();
    ReqL = 1'b1; ReqR = 1'b1;
    wait_q(0, 3, 800, ok);
    ReqL = 1'b0; ReqR = 1'b0;
    checks++;
    if (!ok || grantCyc.size() != 3) begin
      errors++; $display("FAIL rr_frames: got %0d acks %0d grants required 3", ackCyc.size(), grantCyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        exp = 1 - modelLast;
        checks += 2;
        if (grantChQ[k] !== exp) begin errors++; $display("FAIL rr_grant%0d: got %0d required %0d", k, grantChQ[k], exp); end
        if (ackChQ[k] !== exp) begin errors++; $display("FAIL rr_ack%0d: got %0d required %0d", k, ackChQ[k], exp); end
        if (k < 2) begin
          checks++;
          if (grantCyc[k+1] !== ackCyc[k] + 2) begin
            errors++; $display("FAIL rr_regrant%0d: got cycle %0d required %0d", k, grantCyc[k+1], ackCyc[k] + 2);
          end
        end
        modelLast = exp;
      end
      checks += 2;
      if (pulseAddr[16] !== 'h10) begin errors++; $display("FAIL rr_rfirst: got %h required 10", pulseAddr[16]); end
      if (pulseAddr[31] !== 'h1f) begin errors++; $display("FAIL rr_rlast: got %h required 1f", pulseAddr[31]); end
    end
    repeat (2) @(posedge Clock); #1;
  endtask

  task automatic test_random_requests();
    bit ok;
    logic [1:0] pat;
    int exp;
    for (int r = 0; r < 6; r++) begin
      pat = 2'($urandom_range(1, 3));
      exp = (pat == 2'b11) ? 1 - modelLast : int'(pat[1]);
      busyLen = int'($urandom_range(0, 2)); expGap = int'($urandom_range(0, 7)); Gap = 3'(expGap);
      clear_log();
      ReqL = pat[0]; ReqR = pat[1];
      wait_q(0, 1, 300, ok);
      ReqL = 1'b0; ReqR = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_timeout: got no ack required one"); end
      else begin
        checks += 2;
        if (grantChQ[0] !== exp) begin errors++; $display("FAIL rand_grant: pattern %b got %0d required %0d", pat, grantChQ[0], exp); end
        if (ackChQ[0] !== exp) begin errors++; $display("FAIL rand_ack: got %0d required %0d", ackChQ[0], exp); end
        modelLast = exp;
      end
      repeat (2) @(posedge Clock); #1;
    end
  endtask

  task automatic test_throughput();
    bit ok;
    busyLen = 0; expGap = int'($urandom_range(0, 7)); Gap = 3'(expGap);
    clear_log();
    ReqL = 1'b1;
    repeat (3) @(posedge Clock); #1;
    Gap = ~Gap;
    wait_q(0, 1, 200, ok);
    ReqL = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL tput_timeout: got no ack required one"); end
    else begin
      checks += 4;
      if (ackCyc[0] - (grantCyc[0] - 1) !== 5 * NB + 1) begin
        errors++; $display("FAIL tput_latency: got %0d required %0d", ackCyc[0] - (grantCyc[0] - 1), 5 * NB + 1);
      end
      if (pulseAddr.size() !== NB) begin errors++; $display("FAIL tput_pulses: got %0d required %0d", pulseAddr.size(), NB); end
      if (adjCnt !== 0) begin errors++; $display("FAIL tput_adjacent: got %0d required 0", adjCnt); end
      if (ackChQ[0] !== 0) begin errors++; $display("FAIL tput_ackch: got %0d required 0", ackChQ[0]); end
      modelLast = 0;
    end
    repeat (2) @(posedge Clock); #1;
  endtask

  task automatic test_abort();
    bit ok;
    // Abort while waiting on the complementer at bar 7.
    busyLen = 4; expGap = int'($urandom_range(0, 7)); Gap = 3'(expGap);
    clear_log();
    ReqL = 1'b1;
    wait_q(1, 8, 200, ok);
    @(posedge Clock); #1;
    checks++;
    if (!ok || pulseAddr.size() !== 8) begin errors++; $display("FAIL abort_reach: got %0d pulses required 8", pulseAddr.size()); end
    Abort = 1'b1;
    @(posedge Clock); #1;
    Abort = 1'b0;
    checks += 3;
    if (Busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b required 0", Busy); end
    if (CStart !== 1'b0) begin errors++; $display("FAIL abort_cstart: got %b required 0", CStart); end
    if (ackCyc.size() !== 0) begin errors++; $display("FAIL abort_noack: got %0d acks required 0", ackCyc.size()); end
    clear_log();
    wait_q(0, 1, 300, ok);
    ReqL = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_regrant: got no ack required one"); end
    else begin
      checks += 2;
      if (pulseAddr[0] !== 0) begin errors++; $display("FAIL abort_restart: got %h required 0", pulseAddr[0]); end
      if (pulseAddr.size() !== NB) begin errors++; $display("FAIL abort_pulses: got %0d required %0d", pulseAddr.size(), NB); end
      modelLast = 0;
    end
    repeat (3) @(posedge Clock); #1;
    // Abort in IDLE blocks the grant; abort in RD cancels it.
    ReqL = 1'b1; Abort = 1'b1;
    @(posedge Clock); #1;
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL abort_idle_block: got busy %b required 0", Busy); end
    Abort = 1'b0;
    @(posedge Clock); #1;
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL abort_late_grant: got busy %b required 1", Busy); end
    Abort = 1'b1;
    @(posedge Clock); #1;
    Abort = 1'b0; ReqL = 1'b0;
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL abort_rd: got busy %b required 0", Busy); end
    repeat (3) @(posedge Clock); #1;
    // Abort on FIN: no ack and LastCh must stay as it was.
    busyLen = 0;
    clear_log();
    ReqR = 1'b1;
    wait_q(1, 16, 200, ok);
    repeat (2) @(posedge Clock); #1;
    Abort = 1'b1;
    #1;
    checks++;
    if (AckR !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL abort_fin_ack: got ackr %b busy %b required 0 1", AckR, Busy); end
    @(posedge Clock); #1;
    Abort = 1'b0; ReqL = 1'b1; ReqR = 1'b1;
    checks += 2;
    if (Busy !== 1'b0) begin errors++; $display("FAIL abort_fin_idle: got busy %b required 0", Busy); end
    if (ackCyc.size() !== 0) begin errors++; $display("FAIL abort_fin_noack: got %0d acks required 0", ackCyc.size()); end
    clear_log();
    wait_q(2, 1, 20, ok);
    checks++;
    if (!ok || grantChQ[0] !== 1 - modelLast) begin
      errors++; $display("FAIL abort_lastch: got grant %0d required %0d", ok ? grantChQ[0] : -1, 1 - modelLast);
    end
    Abort = 1'b1;
    @(posedge Clock); #1;
    Abort = 1'b0; ReqL = 1'b0; ReqR = 1'b0;
    repeat (3) @(posedge Clock); #1;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    busyLen = 4; expGap = int'($urandom_range(1, 7)); Gap = 3'(expGap);
    clear_log();
    ReqL = 1'b1;
    wait_q(1, 5, 200, ok);
    repeat (7) @(posedge Clock); #1;
    checks++;
    if (CStart !== 1'b1) begin errors++; $display("FAIL rstmid_pulse: got cstart %b required 1", CStart); end
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0; ReqR = 1'b1;
    modelLast = 1;
    checks += 9;
    if (Busy !== 1'b0)   begin errors++; $display("FAIL rstmid_busy: got %b required 0", Busy); end
    if (CStart !== 1'b0) begin errors++; $display("FAIL rstmid_cstart: got %b required 0", CStart); end
    if (AckL !== 1'b0 || AckR !== 1'b0) begin errors++; $display("FAIL rstmid_ack: got %b%b required 00", AckL, AckR); end
    if (RdAddr !== 5'd0) begin errors++; $display("FAIL rstmid_rdaddr: got %h required 0", RdAddr); end
    if (CBar !== 7'd0)   begin errors++; $display("FAIL rstmid_cbar: got %h required 0", CBar); end
    if (CH !== 3'd0)     begin errors++; $display("FAIL rstmid_ch_height: got %h required 0", CH); end
    if (Ch !== 1'b0)     begin errors++; $display("FAIL rstmid_ch: got %b required 0", Ch); end
    if (ackCyc.size() !== 0) begin errors++; $display("FAIL rstmid_noack: got %0d acks required 0", ackCyc.size()); end
    if (pulseAddr.size() !== 6) begin errors++; $display("FAIL rstmid_pulses: got %0d required 6", pulseAddr.size()); end
    clear_log();
    wait_q(0, 1, 300, ok);
    ReqL = 1'b0; ReqR = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_timeout: got no ack required one"); end
    else begin
      checks += 2;
      if (grantChQ[0] !== 0) begin errors++; $display("FAIL rstmid_first: got %0d required 0", grantChQ[0]); end
      if (ackChQ[0] !== 0) begin errors++; $display("FAIL rstmid_ackch: got %0d required 0", ackChQ[0]); end
      modelLast = 0;
    end
    repeat (2) @(posedge Clock); #1;
  endtask

  task automatic test_stuck_busy();
    bit ok;
    logic [4:0] held;
    busyLen = 3; expGap = int'($urandom_range(0, 7)); Gap = 3'(expGap);
    clear_log();
    ReqR = 1'b1;
    wait_q(1, 3, 200, ok);
    stuck = 1'b1;
    repeat (2) @(posedge Clock); #1;
    held = RdAddr;
    repeat (60) @(posedge Clock); #1;
    checks += 5;
    if (RdAddr !== held) begin errors++; $display("FAIL stuck_addr: got %h required %h", RdAddr, held); end
    if (Busy !== 1'b1) begin errors++; $display("FAIL stuck_busy: got %b required 1", Busy); end
    if (pulseAddr.size() !== 3) begin errors++; $display("FAIL stuck_pulses: got %0d required 3", pulseAddr.size()); end
    if (CStart !== 1'b0) begin errors++; $display("FAIL stuck_cstart: got %b required 0", CStart); end
    if (ackCyc.size() !== 0) begin errors++; $display("FAIL stuck_noack: got %0d required 0", ackCyc.size()); end
    stuck = 1'b0;
    wait_q(0, 1, 300, ok);
    ReqR = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL stuck_timeout: got no ack required one"); end
    else begin
      checks += 3;
      if (ackChQ[0] !== 1) begin errors++; $display("FAIL stuck_ackch: got %0d required 1", ackChQ[0]); end
      if (pulseAddr.size() !== NB) begin errors++; $display("FAIL stuck_total: got %0d required %0d", pulseAddr.size(), NB); end
      if (pulseAddr[NB-1] !== 'h1f) begin errors++; $display("FAIL stuck_last: got %h required 1f", pulseAddr[NB-1]); end
      modelLast = 1;
    end
    repeat (2) @(posedge Clock); #1;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_random_requests();
    test_throughput();
    test_abort();
    test_reset_midframe();
    test_stuck_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
